// File: rtl/sprite_pkg.sv
// sprite_pkg: shared FSM state type and default sizes for the sprite RAM reader.
package sprite_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 16;
    localparam int RAM_WORDS  = 1024;
endpackage

// File: rtl/reader_fifo.sv
// reader_fifo: synchronous FIFO with occupancy count.
// Ports: push_i/wdata_i write side, pop_i read side (ignored when empty),
// rdata_o head word (0 when empty), count_o current occupancy.
module reader_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push_i,
    input  logic [DATA_W-1:0]             wdata_i,
    input  logic                          pop_i,
    output logic [DATA_W-1:0]             rdata_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [AW:0]       count_q;
    logic              pop_ok;
    assign pop_ok  = pop_i && (count_q != '0);
    assign count_o = count_q;
    assign rdata_o = (count_q != '0) ? mem_q[rptr_q] : '0;
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q] <= wdata_i;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            assert (!(push_i && !pop_ok && count_q == (AW+1)'(FIFO_DEPTH)));
            if (push_i) wptr_q <= wptr_q + AW'(1);
            if (pop_ok) rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_ok);
        end
    end
endmodule

// File: rtl/sprite_mem_reader.sv
// sprite_mem_reader: Avalon-MM burst reader from sprite RAM to a valid/ready stream.
// Ports: start/base_addr/length request a transfer, busy/done report it;
// avm_* drive the RAM slave; out_* carry the words downstream with out_last on the final one.
module sprite_mem_reader import sprite_pkg::*; #(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     length,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_chipselect,
    output logic                avm_read,
    output logic [DATA_W/8-1:0] avm_byteenable,
    input  logic [DATA_W-1:0]   avm_readdata,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W:0] ONE = 1;
    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [ADDR_W:0]         len_q, len_d, issued_q, issued_d, popped_q, popped_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic                    done_q, done_d;
    logic [CW-1:0]           inflight, fifo_count;
    logic [CW:0]             occupancy;
    logic                    pop;
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(vld_q[i]);
    end
    // Reads in flight plus buffered words never exceed the FIFO, so returns always fit.
    assign occupancy      = {1'b0, inflight} + {1'b0, fifo_count};
    assign avm_read       = (state_q == RUN) && (issued_q < len_q) && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign avm_chipselect = avm_read;
    assign avm_address    = addr_q;
    assign avm_byteenable = '1;
    assign out_valid      = fifo_count != '0;
    assign pop            = out_valid && out_ready;
    assign out_last       = out_valid && (popped_q == len_q - ONE);
    assign busy           = state_q != IDLE;
    assign done           = done_q;
    reader_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (vld_q[READ_LATENCY-1]),
        .wdata_i (avm_readdata),
        .pop_i   (pop),
        .rdata_o (out_data),
        .count_o (fifo_count)
    );
    always_comb begin
        state_d  = state_q;
        addr_d   = avm_read ? addr_q + ADDR_W'(1) : addr_q;
        len_d    = len_q;
        issued_d = avm_read ? issued_q + ONE : issued_q;
        popped_d = pop ? popped_q + ONE : popped_q;
        done_d   = 1'b0;
        vld_d    = (vld_q << 1) | READ_LATENCY'(avm_read);
        case (state_q)
            IDLE: if (start) begin
                if (length != '0) begin
                    state_d  = RUN;
                    addr_d   = base_addr;
                    len_d    = length;
                    issued_d = '0;
                    popped_d = '0;
                end else begin
                    done_d = 1'b1;
                end
            end
            RUN: if (avm_read && issued_q + ONE == len_q) state_d = DRAIN;
            DRAIN: if (pop && popped_q + ONE == len_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            popped_q <= '0;
            vld_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            popped_q <= popped_d;
            vld_q    <= vld_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: tb/tb_sprite_mem_reader.sv
// tb_sprite_mem_reader: scoreboard bench for sprite_mem_reader against a RAM and stream model.
module tb_sprite_mem_reader;
    import sprite_pkg::*;
    localparam int DEPTH = 4;
    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } exp_t;
    logic        clk = 0;
    logic        reset, start, out_ready;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic        busy, done, avm_chipselect, avm_read, out_valid, out_last;
    logic [9:0]  avm_address;
    logic [1:0]  avm_byteenable;
    logic [15:0] avm_readdata, out_data;
    logic [15:0] mem [RAM_WORDS];
    exp_t        exp_q [$];
    logic [9:0]  adr_q [$];
    int          total = 0, bad = 0, outstanding = 0, pops_seen = 0;
    bit          arm = 0, rdy_rand = 0, rdy_val = 1, prev_stall = 0;
    logic [15:0] prev_data;

    always #5 clk = ~clk;

    sprite_mem_reader dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_read(avm_read), .avm_byteenable(avm_byteenable), .avm_readdata(avm_readdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    always @(posedge clk) avm_readdata <= mem[avm_address];

    initial begin
        out_ready = 1;
        forever begin
            @(posedge clk);
            #1 out_ready = rdy_rand ? 1'($urandom % 2) : rdy_val;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            adr_q.delete();
            arm = 0;
            outstanding = 0;
            prev_stall = 0;
        end else begin
            total++;
            if (done !== arm) begin
                bad++;
                $display("FAIL done: got %b want %b", done, arm);
            end
            arm = start && length == 0;
            if (prev_stall) begin
                total++;
                if (!out_valid || out_data !== prev_data) begin
                    bad++;
                    $display("FAIL hold: valid %b data %h want %h", out_valid, out_data, prev_data);
                end
            end
            if (avm_read) begin
                outstanding++;
                total++;
                if (adr_q.size() == 0) begin
                    bad++;
                    $display("FAIL read: unexpected read at %h", avm_address);
                end else begin
                    logic [9:0] a;
                    a = adr_q.pop_front();
                    if (avm_address !== a || avm_chipselect !== 1'b1) begin
                        bad++;
                        $display("FAIL addr: got %h cs %b want %h", avm_address, avm_chipselect, a);
                    end
                end
            end
            if (out_valid && out_ready) begin
                outstanding--;
                pops_seen++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL word: unexpected word %h", out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (out_data !== e.d || out_last !== e.l) begin
                        bad++;
                        $display("FAIL word: got %h last %b want %h last %b", out_data, out_last, e.d, e.l);
                    end
                    if (e.l) arm = 1;
                end
            end
            total++;
            if (outstanding > DEPTH) begin
                bad++;
                $display("FAIL credit: outstanding %0d exceeds %0d", outstanding, DEPTH);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic do_start(input logic [9:0] b, input logic [10:0] n);
        base_addr = b;
        length    = n;
        start     = 1;
        for (int i = 0; i < int'(n); i++) begin
            logic [9:0] a;
            a = b + 10'(i);
            adr_q.push_back(a);
            exp_q.push_back('{d: mem[a], l: (i == int'(n) - 1)});
        end
        @(posedge clk);
        #1 start = 0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(posedge clk);
            #1 k++;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL timeout: no done within %0d cycles", budget);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string name);
        total++;
        if ({busy, done, avm_read, avm_chipselect, out_valid, out_last, avm_address, out_data} !== '0
            || avm_byteenable !== 2'b11) begin
            bad++;
            $display("FAIL %s: busy %b done %b rd %b cs %b v %b last %b addr %h data %h be %b want zeros/be=11",
                     name, busy, done, avm_read, avm_chipselect, out_valid, out_last, avm_address, out_data, avm_byteenable);
        end
    endtask

    initial begin
        for (int i = 0; i < RAM_WORDS; i++) mem[i] = 16'(i) ^ 16'hA5A5;
        reset = 1;
        start = 0;
        base_addr = 0;
        length = 0;
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset_state");
        reset = 0;
        @(posedge clk);
        #1;
        // basic read with exact latency checks
        do_start(10'h010, 11'd4);
        total++;
        if (!avm_read || avm_address !== 10'h010) begin
            bad++;
            $display("FAIL first_read: rd %b addr %h want 1 010", avm_read, avm_address);
        end
        begin
            int k = 1;
            while (!out_valid && k < 20) begin
                @(posedge clk);
                #1 k++;
            end
            total++;
            if (k != 3) begin
                bad++;
                $display("FAIL first_valid: cycle T0+%0d want T0+3", k);
            end
        end
        wait_done(50);
        // backpressure
        do_start(10'($urandom), 11'd16);
        rdy_val = 0;
        repeat (10) @(posedge clk);
        #1 rdy_val = 1;
        wait_done(200);
        // wrap-around
        do_start(10'h3FE, 11'd4);
        wait_done(50);
        // zero length
        do_start(10'h055, 11'd0);
        total++;
        if (!done) begin
            bad++;
            $display("FAIL zero_done: got %b want 1", done);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL zero_busy: got %b want 0", busy);
            end
            @(posedge clk);
            #1;
        end
        // full RAM with an ignored start mid-transfer
        do_start(10'h000, 11'd1024);
        repeat (100) @(posedge clk);
        #1 base_addr = 10'h200;
        length = 11'd5;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        wait_done(2000);
        // random transfers under random backpressure
        rdy_rand = 1;
        for (int t = 0; t < 6; t++) begin
            do_start(10'($urandom), 11'(1 + $urandom % 40));
            wait_done(1000);
        end
        rdy_rand = 0;
        rdy_val = 1;
        repeat (3) @(posedge clk);
        #1;
        // reset mid-transfer
        pops_seen = 0;
        do_start(10'($urandom), 11'd16);
        begin
            int k = 0;
            while (pops_seen < 5 && k < 100) begin
                @(posedge clk);
                #1 k++;
            end
        end
        reset = 1;
        @(posedge clk);
        #1 reset = 0;
        check_idle_outputs("reset_mid");
        repeat (3) @(posedge clk);
        #1 do_start(10'h100, 11'd2);
        wait_done(50);
        repeat (5) @(posedge clk);
        #1 total++;
        if (exp_q.size() != 0 || adr_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: words %0d addrs %0d want 0 0", exp_q.size(), adr_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
